adder_share_sched: RTL and testbench
====================================

Name: adder_share_sched

Overview:
- Time-multiplexes one shared pipelined 4-operand signed adder (Adder_4in-style: WIDTH-bit inputs, 2-register latency, no enable) between NUM_REQ requesters.
- Round-robin arbitration; each transfer tagged with requester ID, tracked through the adder pipeline.
- Results land in a local response FIFO with valid/ready output.
- Credit check prevents issuing results the FIFO cannot hold; adder never needs stalling.

Parameters:
- WIDTH, 8, operand/result width, two's complement.
- NUM_REQ, 4, requester count (2..8).
- ID_W, 2, requester ID width; must satisfy 2^ID_W >= NUM_REQ.
- ADD_LAT, 2, shared adder latency in clock edges (input sample to add_q valid).
- RSP_DEPTH, 4, response FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  clock; also clocks the shared adder.
- rstn  in  1  asynchronous active-low reset; also drives the adder.
- en  in  1  1 = new grants allowed; 0 = drain only.
- req_valid  in  NUM_REQ  per-requester request.
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid & ready.
- req_data  in  NUM_REQ*4*WIDTH  requester i at bits [i*4*WIDTH +: 4*WIDTH]; operand k at [k*WIDTH +: WIDTH] within the slice.
- add_d0..add_d3  out  WIDTH each  to adder D0_i..D3_i.
- add_q  in  WIDTH  from adder Q_o.
- rsp_valid  out  1  FIFO head valid.
- rsp_ready  in  1  consumer accepts head.
- rsp_id  out  ID_W  requester of head result.
- rsp_data  out  WIDTH  head sum.
- busy  out  1  any tag in flight or FIFO non-empty.

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous and active-low on rstn.
- Reset values:
  - req_ready = 0; add_d* = 0; rsp_valid = 0; rsp_id = 0; rsp_data = 0; busy = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - Tag pipeline and FIFO cleared.
- Reset mid-operation: in-flight tags and FIFO contents are discarded. No response is ever emitted for them.
- Credit:
  - inflight = number of valid tag stages; occ = FIFO count.
  - Grant allowed only when en=1 and occ + inflight < RSP_DEPTH.
  - A same-cycle pop does not count as freed space (conservative; no combinational path from rsp_ready to req_ready).
- Arbitration (combinational in-cycle):
  - Search req_valid starting at pointer+1, wrapping modulo NUM_REQ; first set bit wins.
  - req_ready = one-hot of the winner when the grant is allowed; else 0.
  - req_ready may depend on req_valid; requesters must not depend on req_ready to raise valid.
  - Pointer updates to the winner only on a transfer.
  - At most one transfer per cycle.
- Operand drive:
  - On a transfer cycle, add_d0..3 = the winner's four operands, combinationally muxed.
  - Otherwise add_d* = 0, so the idle adder output is deterministic.
  - The adder samples at the transfer edge.
- Tag pipeline:
  - ADD_LAT-stage shift register of {valid, id}, shifting every cycle.
  - Stage 0 loads {transfer, winner id} at the transfer edge.
  - Stage ADD_LAT-1 valid means add_q holds that tag's sum in the current cycle.
- Capture: when stage ADD_LAT-1 is valid, {id, add_q} is written to the FIFO at the next edge. The credit rule guarantees the FIFO is never full at write.
- Latency: transfer at edge E makes rsp_valid visible after edge E+ADD_LAT (ADD_LAT+1 cycles later), given an empty FIFO.
- Response FIFO:
  - Show-ahead FIFO with registered count.
  - rsp_* reflect the head; pop on rsp_valid & rsp_ready.
  - Simultaneous write and pop are legal: count unchanged, order preserved.
  - Pop when empty is ignored.
  - rsp_data/rsp_id hold their last value when empty.
- Ordering: responses are emitted strictly in grant order.
- Arithmetic: the sum wraps modulo 2^WIDTH; the block passes add_q unmodified. No saturation, no overflow flag.
- en deasserted: req_ready forced 0 from that cycle. In-flight tags still complete and FIFO still drains.
- Stalled requester: a requester holding valid while not granted must keep its data stable. The arbiter does not latch data.
- busy = (inflight != 0) | (occ != 0), registered-equivalent (derived from state only).

Test Plan:
- Single request, req0 ops {10, 20, -5, 3}, rsp_ready=1 -> req_ready[0] high same cycle; rsp_valid 3 cycles later; rsp_id=0, rsp_data=28; busy high from edge after transfer until pop.
- Wrap, WIDTH=8, req2 ops {100, 100, 0, 0} -> rsp_data = -56 (0xC8), rsp_id=2.
- All four req_valid held high, distinct ops, rsp_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles; responses in the same id order, one per cycle, sums correct.
- Backpressure: rsp_ready=0, all requesters valid -> exactly RSP_DEPTH=4 transfers, then req_ready=0. One pop -> next grant occurs the cycle after the pop, not the same cycle. No FIFO overflow.
- en=0 with two tags in flight -> no new req_ready. Both responses still appear; busy falls after the last pop.
- rstn asserted with two tags in flight and two FIFO entries -> all outputs zero immediately. After release, no stale responses; first grant goes to requester 0.

Source files
------------

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one external pipelined 4-operand adder between NUM_REQ requesters.
// Results are tagged with the requester ID and queued in a credit-protected show-ahead response FIFO.
module adder_share_sched #(
    parameter int WIDTH     = 8,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = 2,
    parameter int ADD_LAT   = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*4*WIDTH-1:0]   req_data,
    output logic [WIDTH-1:0]             add_d0,
    output logic [WIDTH-1:0]             add_d1,
    output logic [WIDTH-1:0]             add_d2,
    output logic [WIDTH-1:0]             add_d3,
    input  logic [WIDTH-1:0]             add_q,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [WIDTH-1:0]             rsp_data,
    output logic                         busy
);

    localparam int OPS_W = 4 * WIDTH;
    localparam int AW    = $clog2(RSP_DEPTH);
    localparam int CW    = $clog2(RSP_DEPTH + ADD_LAT + 1);
    localparam int EW    = ID_W + WIDTH;

    logic [ID_W-1:0]  rr_ptr;
    logic             run_q;
    logic [ADD_LAT-1:0] tag_v;
    logic [ID_W-1:0]  tag_id [ADD_LAT];

    logic [EW-1:0]    fifo_mem [RSP_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic [EW-1:0]    last_q;
    logic [EW-1:0]    head;

    logic [CW-1:0]    inflight;
    logic             credit_ok;
    logic             grant_ok;
    logic             win_found;
    logic [ID_W-1:0]  win_id;
    logic [ID_W-1:0]  cand;
    logic             xfer;
    logic [OPS_W-1:0] win_ops;
    logic             wr_en;
    logic             rd_en;

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        inflight = '0;
        for (int k = 0; k < ADD_LAT; k++) begin
            inflight = inflight + CW'(tag_v[k]);
        end
    end

    // A pop in the current cycle is deliberately not counted as free space.
    assign credit_ok = (CW'(occ) + inflight) < CW'(RSP_DEPTH);
    // run_q keeps grants off while rstn is low without using rstn as a data signal.
    assign grant_ok  = run_q & en & credit_ok;

    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    assign xfer      = grant_ok & win_found;
    assign req_ready = xfer ? (NUM_REQ'(1) << win_id) : '0;
    assign win_ops   = OPS_W'(req_data >> (int'(win_id) * OPS_W));

    // Idle cycles feed zeros so the adder output stays deterministic.
    assign {add_d3, add_d2, add_d1, add_d0} = xfer ? win_ops : '0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= ID_W'(NUM_REQ - 1);
            run_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (xfer) begin
                rr_ptr <= win_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tag_v <= '0;
            for (int k = 0; k < ADD_LAT; k++) begin
                tag_id[k] <= '0;
            end
        end else begin
            tag_v[0]  <= xfer;
            tag_id[0] <= win_id;
            for (int k = 1; k < ADD_LAT; k++) begin
                tag_v[k]  <= tag_v[k-1];
                tag_id[k] <= tag_id[k-1];
            end
        end
    end

    assign wr_en = tag_v[ADD_LAT-1];
    assign rd_en = (occ != '0) & rsp_ready;

    // NOTE: the FIFO storage is not reset; occ gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            fifo_mem[wr_ptr] <= {tag_id[ADD_LAT-1], add_q};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
            last_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
                last_q <= fifo_mem[rd_ptr];
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    // When empty the outputs hold the most recently popped entry.
    assign head               = (occ != '0) ? fifo_mem[rd_ptr] : last_q;
    assign {rsp_id, rsp_data} = head;
    assign rsp_valid          = (occ != '0);
    assign busy               = (inflight != '0) | (occ != '0);

endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched: external 2-stage adder model, directed scenarios
// and a randomized phase, all compared against a queue-based model of grants and responses.
module tb_adder_share_sched;

    localparam int WIDTH     = 8;
    localparam int NUM_REQ   = 4;
    localparam int ID_W      = 2;
    localparam int ADD_LAT   = 2;
    localparam int RSP_DEPTH = 4;

    typedef struct {
        int               id;
        logic [WIDTH-1:0] data;
        int               rdy;
    } rsp_t;

    logic                       clk = 1'b0;
    logic                       rstn = 1'b0;
    logic                       en = 1'b0;
    logic                       rsp_ready = 1'b0;
    logic [NUM_REQ-1:0]         req_valid = '0;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ*4*WIDTH-1:0] req_data;
    logic [WIDTH-1:0]           add_d0, add_d1, add_d2, add_d3;
    logic [WIDTH-1:0]           add_q;
    logic                       rsp_valid;
    logic [ID_W-1:0]            rsp_id;
    logic [WIDTH-1:0]           rsp_data;
    logic                       busy;

    logic signed [WIDTH-1:0]    ops [NUM_REQ][4];
    logic [WIDTH-1:0]           s1;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    rsp_t q[$];
    int   last_win = NUM_REQ - 1;
    int   last_id  = 0;
    logic [WIDTH-1:0] last_data = '0;
    bit   run_m = 1'b0;
    int   last_grant = -1;

    int   grant_log[$];
    int   obs_pops = 0;
    int   obs_pop_cyc = 0;
    int   obs_id = 0;
    logic [WIDTH-1:0] obs_data = '0;

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int k = 0; k < 4; k++) begin
                req_data[(i*4+k)*WIDTH +: WIDTH] = ops[i][k];
            end
        end
    end

    // Shared adder: inputs sampled at one edge, sum on add_q after the next.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1    <= '0;
            add_q <= '0;
        end else begin
            s1    <= add_d0 + add_d1 + add_d2 + add_d3;
            add_q <= s1;
        end
    end

    adder_share_sched #(
        .WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .ID_W(ID_W),
        .ADD_LAT(ADD_LAT), .RSP_DEPTH(RSP_DEPTH)
    ) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .add_d0(add_d0), .add_d1(add_d1), .add_d2(add_d2), .add_d3(add_d3),
        .add_q(add_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int oh2id(input logic [NUM_REQ-1:0] v);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check all outputs at the falling edge, advance the model, return at posedge+1.
    task automatic tick();
        int                  win;
        bit                  found;
        bit                  exp_v;
        int                  sum;
        logic [NUM_REQ-1:0]  exp_rdy;
        logic [4*WIDTH-1:0]  exp_d;
        @(negedge clk);
        if (!rstn) begin
            q.delete();
            last_win  = NUM_REQ - 1;
            last_id   = 0;
            last_data = '0;
            run_m     = 1'b0;
        end
        found = 1'b0;
        win   = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && req_valid[(last_win + i) % NUM_REQ]) begin
                found = 1'b1;
                win   = (last_win + i) % NUM_REQ;
            end
        end
        exp_rdy = (run_m && en && found && q.size() < RSP_DEPTH) ? (NUM_REQ'(1) << win) : '0;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        exp_d = (exp_rdy != '0) ? {ops[win][3], ops[win][2], ops[win][1], ops[win][0]} : '0;
        check("add_d", 64'({add_d3, add_d2, add_d1, add_d0}), 64'(exp_d));
        exp_v = (q.size() > 0) && (q[0].rdy <= cyc);
        check("rsp_valid", 64'(rsp_valid), 64'(exp_v));
        check("rsp_id", 64'(rsp_id), exp_v ? 64'(q[0].id) : 64'(last_id));
        check("rsp_data", 64'(rsp_data), exp_v ? 64'(q[0].data) : 64'(last_data));
        check("busy", 64'(busy), 64'(q.size() != 0));

        if (rsp_valid && rsp_ready) begin
            obs_id      = int'(rsp_id);
            obs_data    = rsp_data;
            obs_pop_cyc = cyc;
            obs_pops++;
        end
        if (req_ready != '0) grant_log.push_back(oh2id(req_ready));

        if (exp_v && rsp_ready) begin
            last_id   = q[0].id;
            last_data = q[0].data;
            void'(q.pop_front());
        end
        last_grant = -1;
        if (exp_rdy != '0) begin
            sum = int'(ops[win][0]) + int'(ops[win][1]) + int'(ops[win][2]) + int'(ops[win][3]);
            q.push_back('{win, WIDTH'(sum), cyc + ADD_LAT + 1});
            last_win   = win;
            last_grant = win;
        end
        if (rstn) run_m = 1'b1;
        cyc++;
        @(posedge clk);
        #1;
        if (last_grant >= 0) begin
            for (int k = 0; k < 4; k++) ops[last_grant][k] = WIDTH'($urandom);
        end
    endtask

    initial begin
        int n0;
        int p0;
        int t0;
        for (int i = 0; i < NUM_REQ; i++)
            for (int k = 0; k < 4; k++) ops[i][k] = WIDTH'($urandom);

        // Reset state.
        req_valid = '1;
        en        = 1'b1;
        repeat (2) tick();
        rstn      = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (2) tick();

        // Single request, latency and sum.
        ops[0][0] = 8'sd10; ops[0][1] = 8'sd20; ops[0][2] = -8'sd5; ops[0][3] = 8'sd3;
        req_valid = 4'b0001;
        n0 = grant_log.size();
        t0 = cyc;
        tick();
        check("t1_grant", 64'(grant_log.size() - n0), 64'(1));
        req_valid = '0;
        repeat (5) tick();
        check("t1_id", 64'(obs_id), 64'(0));
        check("t1_data", 64'(obs_data), 64'(28));
        check("t1_lat", 64'(obs_pop_cyc - t0), 64'(3));

        // Wrap-around sum.
        ops[2][0] = 8'sd100; ops[2][1] = 8'sd100; ops[2][2] = 8'sd0; ops[2][3] = 8'sd0;
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        repeat (5) tick();
        check("t2_id", 64'(obs_id), 64'(2));
        check("t2_data", 64'(obs_data), 64'(8'hC8));

        // All requesters valid: round-robin from requester 0.
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        tick();
        n0 = grant_log.size();
        p0 = obs_pops;
        req_valid = '1;
        repeat (6) tick();
        req_valid = '0;
        repeat (6) tick();
        check("t3_ngrants", 64'(grant_log.size() - n0), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (n0 + i < grant_log.size())
                check("t3_order", 64'(grant_log[n0 + i]), 64'(i % NUM_REQ));
        end
        check("t3_pops", 64'(obs_pops - p0), 64'(6));

        // Backpressure and conservative credit return.
        rsp_ready = 1'b0;
        req_valid = '1;
        n0 = grant_log.size();
        repeat (8) tick();
        check("t4_grants", 64'(grant_log.size() - n0), 64'(RSP_DEPTH));
        rsp_ready = 1'b1;
        tick();
        check("t4_no_same_cycle", 64'(grant_log.size() - n0), 64'(RSP_DEPTH));
        rsp_ready = 1'b0;
        tick();
        check("t4_regrant", 64'(grant_log.size() - n0), 64'(RSP_DEPTH + 1));
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (10) tick();

        // en low with two tags in flight.
        p0 = obs_pops;
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        n0 = grant_log.size();
        en = 1'b0;
        req_valid = '1;
        repeat (6) tick();
        check("t5_no_grant", 64'(grant_log.size() - n0), 64'(0));
        check("t5_pops", 64'(obs_pops - p0), 64'(2));
        check("t5_busy", 64'(busy), 64'(0));
        en = 1'b1;
        req_valid = '0;
        tick();

        // Reset with two entries queued and two in flight.
        rsp_ready = 1'b0;
        req_valid = '1;
        repeat (4) tick();
        rstn = 1'b0;
        #1;
        check("t6_rst_outs", 64'({rsp_valid, busy, req_ready, add_d3, add_d2, add_d1, add_d0, rsp_id, rsp_data}), 64'(0));
        tick();
        rstn = 1'b1;
        rsp_ready = 1'b1;
        p0 = obs_pops;
        n0 = grant_log.size();
        repeat (2) tick();
        check("t6_first_grant", 64'((grant_log.size() > n0) ? grant_log[n0] : -1), 64'(0));
        req_valid = '0;
        repeat (6) tick();
        check("t6_no_stale", 64'(obs_pops - p0), 64'(1));

        // Randomized traffic; a requester holds valid and data until granted.
        for (int c = 0; c < 400; c++) begin
            en        = ($urandom_range(0, 9) != 0);
            rsp_ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < NUM_REQ; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) req_valid[i] = 1'b1;
            tick();
            if (last_grant >= 0) req_valid[last_grant] = 1'b0;
        end
        req_valid = '0;
        en        = 1'b1;
        rsp_ready = 1'b1;
        repeat (12) tick();
        check("end_busy", 64'(busy), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
